// File: rtl/pa_fcnvt_ftoi_s_if.sv
// ---------------------------------------------------------------------------
// pa_fcnvt_ftoi_s_if
// Handshake bundle for the float-to-integer converter.
//   master : producer/consumer side (drives operands, flush and out_rdy)
//   slave  : converter side (drives in_rdy and the result channel)
// Signals:
//   ftoi_flush                  kill every in-flight operation
//   ftoi_in_vld / ftoi_in_rdy   operand channel handshake
//   ftoi_in_src                 IEEE-754 single operand
//   ftoi_in_sign                1: signed (W) result, 0: unsigned (WU)
//   ftoi_in_rm                  rounding mode
//   ftoi_in_tag                 opaque destination tag
//   ftoi_out_vld / ftoi_out_rdy result channel handshake
//   ftoi_out_rst                integer result
//   ftoi_out_fflags             {NV,DZ,OF,UF,NX}
//   ftoi_out_tag                tag travelling with the result
// ---------------------------------------------------------------------------
interface pa_fcnvt_ftoi_s_if #(
    parameter int TAG_W = 5
);
    logic             ftoi_flush;
    logic             ftoi_in_vld;
    logic             ftoi_in_rdy;
    logic [31:0]      ftoi_in_src;
    logic             ftoi_in_sign;
    logic [2:0]       ftoi_in_rm;
    logic [TAG_W-1:0] ftoi_in_tag;
    logic             ftoi_out_vld;
    logic             ftoi_out_rdy;
    logic [31:0]      ftoi_out_rst;
    logic [4:0]       ftoi_out_fflags;
    logic [TAG_W-1:0] ftoi_out_tag;

    modport master (
        output ftoi_flush,
        output ftoi_in_vld,
        input  ftoi_in_rdy,
        output ftoi_in_src,
        output ftoi_in_sign,
        output ftoi_in_rm,
        output ftoi_in_tag,
        input  ftoi_out_vld,
        output ftoi_out_rdy,
        input  ftoi_out_rst,
        input  ftoi_out_fflags,
        input  ftoi_out_tag
    );

    modport slave (
        input  ftoi_flush,
        input  ftoi_in_vld,
        output ftoi_in_rdy,
        input  ftoi_in_src,
        input  ftoi_in_sign,
        input  ftoi_in_rm,
        input  ftoi_in_tag,
        output ftoi_out_vld,
        input  ftoi_out_rdy,
        output ftoi_out_rst,
        output ftoi_out_fflags,
        output ftoi_out_tag
    );
endinterface

// File: rtl/pa_fcnvt_ftoi_s.sv
// ---------------------------------------------------------------------------
// pa_fcnvt_ftoi_s
// Single-precision float to 32-bit integer converter (FCVT.W.S / FCVT.WU.S).
// Two-stage pipeline: stage 1 unpacks and classifies the operand and works
// out the denormalising shift; stage 2 shifts, rounds, range-checks and
// saturates. Valid/ready handshake on both sides, flush kills in-flight ops.
// Ports:
//   forever_cpuclk  clock
//   cpurst          asynchronous active-high reset
//   ftoi            pa_fcnvt_ftoi_s_if.slave handshake bundle
// ---------------------------------------------------------------------------
module pa_fcnvt_ftoi_s #(
    parameter int TAG_W = 5
) (
    input  logic             forever_cpuclk,
    input  logic             cpurst,
    pa_fcnvt_ftoi_s_if.slave ftoi
);

    typedef enum logic [2:0] {
        CLS_NORM,
        CLS_ZERO,
        CLS_SUB,
        CLS_INF,
        CLS_NAN,
        CLS_HUGE
    } cls_e;

    localparam logic [4:0] RSH_MAX = 5'd26;

    function automatic logic f_round_inc(
        input logic [2:0] rm,
        input logic       neg,
        input logic       g,
        input logic       s,
        input logic       lsb
    );
        logic inc;
        case (rm)
            3'b001:  inc = 1'b0;
            3'b010:  inc = neg & (g | s);
            3'b011:  inc = ~neg & (g | s);
            3'b100:  inc = g;
            default: inc = g & (s | lsb);
        endcase
        return inc;
    endfunction

    function automatic logic f_in_range(
        input logic        sgn_mode,
        input logic        neg,
        input logic [32:0] mr
    );
        if (sgn_mode) begin
            return neg ? (mr <= 33'h0_8000_0000) : (mr <= 33'h0_7FFF_FFFF);
        end
        // A negative value that rounds to zero is still representable.
        return ~mr[32] & (~neg | (mr == 33'd0));
    endfunction

    function automatic logic [31:0] f_sat_value(
        input logic sgn_mode,
        input logic neg
    );
        if (neg) begin
            return sgn_mode ? 32'h8000_0000 : 32'h0000_0000;
        end
        return sgn_mode ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
    endfunction

    // ---------------- handshake control ----------------
    logic r_vld_p1;
    logic r_vld_p2;
    logic w_adv_p1;
    logic w_acc_p0;
    logic w_load_p2;

    assign w_adv_p1         = ~r_vld_p2 | ftoi.ftoi_out_rdy;
    assign ftoi.ftoi_in_rdy = ~ftoi.ftoi_flush & (~r_vld_p1 | w_adv_p1);
    assign w_acc_p0         = ftoi.ftoi_in_vld & ftoi.ftoi_in_rdy;
    assign w_load_p2        = r_vld_p1 & w_adv_p1 & ~ftoi.ftoi_flush;

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else if (ftoi.ftoi_flush) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else begin
            if (ftoi.ftoi_in_rdy) begin
                r_vld_p1 <= ftoi.ftoi_in_vld;
            end
            if (w_adv_p1) begin
                r_vld_p2 <= r_vld_p1;
            end
        end
    end

    // ---------------- stage 1: unpack / classify / shift amount ----------------
    logic [7:0]  w_exp_p0;
    logic [22:0] w_frac_p0;
    cls_e        w_cls_p0;
    logic        w_left_p0;
    logic [3:0]  w_lsh_p0;
    logic [7:0]  w_rdist_p0;
    logic [4:0]  w_rsh_p0;

    assign w_exp_p0   = ftoi.ftoi_in_src[30:23];
    assign w_frac_p0  = ftoi.ftoi_in_src[22:0];
    assign w_left_p0  = (w_exp_p0 >= 8'd150);
    // Left shifts only matter for exponents 150..158 (0..8 places); 150 has a
    // low nibble of 6, so the nibble difference is exact in that window.
    assign w_lsh_p0   = w_exp_p0[3:0] - 4'd6;
    assign w_rdist_p0 = 8'd150 - w_exp_p0;
    // Beyond 26 places every mantissa bit is already below the guard bit.
    assign w_rsh_p0   = (w_rdist_p0 > 8'd26) ? RSH_MAX : w_rdist_p0[4:0];

    always_comb begin
        w_cls_p0 = CLS_NORM;
        if (w_exp_p0 == 8'hFF) begin
            w_cls_p0 = (w_frac_p0 != 23'd0) ? CLS_NAN : CLS_INF;
        end else if (w_exp_p0 == 8'd0) begin
            w_cls_p0 = (w_frac_p0 != 23'd0) ? CLS_SUB : CLS_ZERO;
        end else if (w_exp_p0 >= 8'd159) begin
            // Magnitude at least 2^32: out of range in both modes.
            w_cls_p0 = CLS_HUGE;
        end
    end

    cls_e             r_cls_p1;
    logic             r_neg_p1;
    logic [23:0]      r_mant_p1;
    logic             r_left_p1;
    logic [3:0]       r_lsh_p1;
    logic [4:0]       r_rsh_p1;
    logic             r_sgn_p1;
    logic [2:0]       r_rm_p1;
    logic [TAG_W-1:0] r_tag_p1;

    always_ff @(posedge forever_cpuclk) begin
        if (w_acc_p0) begin
            r_cls_p1  <= w_cls_p0;
            r_neg_p1  <= ftoi.ftoi_in_src[31];
            r_mant_p1 <= {1'b1, w_frac_p0};
            r_left_p1 <= w_left_p0;
            r_lsh_p1  <= w_lsh_p0;
            r_rsh_p1  <= w_rsh_p0;
            r_sgn_p1  <= ftoi.ftoi_in_sign;
            r_rm_p1   <= ftoi.ftoi_in_rm;
            r_tag_p1  <= ftoi.ftoi_in_tag;
        end
    end

    // ---------------- stage 2: shift / round / saturate ----------------
    logic [49:0]        w_rwide_p1;
    logic [32:0]        w_mag_p1;
    logic               w_g_p1;
    logic               w_s_p1;
    logic               w_inc_p1;
    logic [32:0]        w_mr_p1;
    logic signed [31:0] w_negv_p1;
    logic               w_nv_p1;
    logic               w_nx_p1;
    logic [31:0]        w_res_p1;

    always_comb begin
        // Mantissa sits above 26 fraction bits: [25] is guard, [24:0] sticky.
        w_rwide_p1 = {r_mant_p1, 26'd0} >> r_rsh_p1;
        w_mag_p1   = 33'd0;
        w_g_p1     = 1'b0;
        w_s_p1     = 1'b0;
        case (r_cls_p1)
            CLS_NORM: begin
                if (r_left_p1) begin
                    w_mag_p1 = {9'd0, r_mant_p1} << r_lsh_p1;
                end else begin
                    w_mag_p1 = {9'd0, w_rwide_p1[49:26]};
                    w_g_p1   = w_rwide_p1[25];
                    w_s_p1   = |w_rwide_p1[24:0];
                end
            end
            CLS_SUB: w_s_p1 = 1'b1;
            default: ;
        endcase

        w_inc_p1  = f_round_inc(r_rm_p1, r_neg_p1, w_g_p1, w_s_p1, w_mag_p1[0]);
        w_mr_p1   = w_mag_p1 + {32'd0, w_inc_p1};
        w_negv_p1 = -$signed(w_mr_p1[31:0]);

        w_nv_p1  = 1'b0;
        w_res_p1 = 32'd0;
        case (r_cls_p1)
            CLS_NAN: begin
                w_nv_p1  = 1'b1;
                w_res_p1 = r_sgn_p1 ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
            end
            CLS_INF, CLS_HUGE: begin
                w_nv_p1  = 1'b1;
                w_res_p1 = f_sat_value(r_sgn_p1, r_neg_p1);
            end
            default: begin
                if (!f_in_range(r_sgn_p1, r_neg_p1, w_mr_p1)) begin
                    w_nv_p1  = 1'b1;
                    w_res_p1 = f_sat_value(r_sgn_p1, r_neg_p1);
                end else begin
                    w_res_p1 = r_neg_p1 ? w_negv_p1 : w_mr_p1[31:0];
                end
            end
        endcase
        w_nx_p1 = ~w_nv_p1 & (w_g_p1 | w_s_p1);
    end

    logic [31:0]      r_res_p2;
    logic [4:0]       r_flags_p2;
    logic [TAG_W-1:0] r_tag_p2;

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            r_res_p2   <= 32'd0;
            r_flags_p2 <= 5'd0;
            r_tag_p2   <= '0;
        end else if (w_load_p2) begin
            r_res_p2   <= w_res_p1;
            r_flags_p2 <= {w_nv_p1, 3'b000, w_nx_p1};
            r_tag_p2   <= r_tag_p1;
        end
    end

    assign ftoi.ftoi_out_vld    = r_vld_p2;
    assign ftoi.ftoi_out_rst    = r_res_p2;
    assign ftoi.ftoi_out_fflags = r_flags_p2;
    assign ftoi.ftoi_out_tag    = r_tag_p2;

endmodule

// File: tb/tb_pa_fcnvt_ftoi_s.sv
// ---------------------------------------------------------------------------
// tb_pa_fcnvt_ftoi_s
// Scoreboard bench for pa_fcnvt_ftoi_s: the driver pushes the expected result
// of each accepted operation, a monitor pops and compares on every output
// transfer and checks that held outputs stay stable.
// ---------------------------------------------------------------------------
module tb_pa_fcnvt_ftoi_s;
    localparam int TAG_W = 5;

    typedef struct packed {
        logic [31:0]      res;
        logic [4:0]       fl;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   rdy_mode;
    logic [TAG_W-1:0] tag_cnt;
    exp_t sb[$];

    pa_fcnvt_ftoi_s_if #(.TAG_W(TAG_W)) bus ();

    pa_fcnvt_ftoi_s #(.TAG_W(TAG_W)) dut (
        .forever_cpuclk (clk),
        .cpurst         (rst),
        .ftoi           (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sat_val(input bit neg, input logic sgn);
        if (neg) return sgn ? 32'h8000_0000 : 32'h0000_0000;
        return sgn ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
    endfunction

    // Reference: value = 1.f * 2^(e-127) as an integer part plus a remainder
    // compared against one half; rounding and range taken on the signed value.
    function automatic void ref_model(input logic [31:0] src, input logic sgn, input logic [2:0] rm,
                                      output logic [31:0] res, output logic [4:0] fl);
        int     e;
        int     sh;
        int     cmp;
        longint m, ip, rem, half, mag, v;
        bit     neg, inexact, up, huge, ok;
        neg     = src[31];
        e       = int'(src[30:23]);
        m       = {40'd0, 1'b1, src[22:0]};
        ip      = 0;
        inexact = 0;
        cmp     = -1;
        huge    = 0;
        if (e == 255) begin
            fl  = 5'b10000;
            res = (src[22:0] != 23'd0) ? (sgn ? 32'h7FFF_FFFF : 32'hFFFF_FFFF) : sat_val(neg, sgn);
            return;
        end
        if (e == 0) begin
            inexact = (src[22:0] != 23'd0);
        end else if (e >= 150) begin
            if (e - 150 > 40) huge = 1;
            else ip = m << (e - 150);
        end else begin
            sh = 150 - e;
            if (sh > 40) begin
                inexact = 1;
            end else begin
                ip      = m >> sh;
                rem     = m - (ip << sh);
                half    = 64'sd1 << (sh - 1);
                inexact = (rem != 0);
                cmp     = (rem < half) ? -1 : ((rem == half) ? 0 : 1);
            end
        end
        case (rm)
            3'd1:    up = 0;
            3'd2:    up = neg && inexact;
            3'd3:    up = !neg && inexact;
            3'd4:    up = inexact && (cmp >= 0);
            default: up = inexact && ((cmp > 0) || ((cmp == 0) && ip[0]));
        endcase
        mag = ip + (up ? 64'sd1 : 64'sd0);
        v   = neg ? -mag : mag;
        if (sgn) ok = (v >= -64'sd2147483648) && (v <= 64'sd2147483647);
        else     ok = (v >= 0) && (v <= 64'sd4294967295);
        if (huge) ok = 0;
        if (ok) begin
            res = v[31:0];
            fl  = inexact ? 5'b00001 : 5'b00000;
        end else begin
            res = sat_val(neg, sgn);
            fl  = 5'b10000;
        end
    endfunction

    // Drive one operation and wait (bounded) for acceptance; returns #1 after
    // the accepting edge so calls chain back-to-back.
    task automatic send(input logic [31:0] src, input logic sgn, input logic [2:0] rm,
                        input logic [31:0] er, input logic [4:0] ef);
        int   n;
        logic acc;
        bus.ftoi_in_vld  = 1'b1;
        bus.ftoi_in_src  = src;
        bus.ftoi_in_sign = sgn;
        bus.ftoi_in_rm   = rm;
        bus.ftoi_in_tag  = tag_cnt;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = bus.ftoi_in_rdy;
            @(posedge clk);
            n++;
        end
        chk("accept", {31'd0, acc}, 32'd1);
        if (acc) begin
            sb.push_back('{res: er, fl: ef, tag: tag_cnt});
            tag_cnt++;
        end
        #1;
        bus.ftoi_in_vld = 1'b0;
    endtask

    task automatic send_m(input logic [31:0] src, input logic sgn, input logic [2:0] rm);
        logic [31:0] r;
        logic [4:0]  f;
        ref_model(src, sgn, rm, r, f);
        send(src, sgn, rm, r, f);
    endtask

    task automatic drain();
        int n;
        rdy_mode = 0;
        n = 0;
        while ((sb.size() != 0 || bus.ftoi_out_vld) && n < 500) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    // out_rdy pattern generator: 0 always ready, 1 random, 2 held low
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.ftoi_out_rdy = 1'b1;
                1:       bus.ftoi_out_rdy = ($urandom_range(0, 3) != 0);
                default: bus.ftoi_out_rdy = 1'b0;
            endcase
        end
    end

    // Monitor: compares on each output transfer and checks held outputs.
    initial begin
        exp_t             e;
        logic             hold;
        logic [31:0]      h_res;
        logic [4:0]       h_fl;
        logic [TAG_W-1:0] h_tag;
        hold = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || bus.ftoi_flush) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("stable_vld", {31'd0, bus.ftoi_out_vld}, 32'd1);
                    chk("stable_res", bus.ftoi_out_rst, h_res);
                    chk("stable_flags", {27'd0, bus.ftoi_out_fflags}, {27'd0, h_fl});
                    chk("stable_tag", 32'(bus.ftoi_out_tag), 32'(h_tag));
                end
                if (bus.ftoi_out_vld && bus.ftoi_out_rdy) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_out: got 0x%08h with no result outstanding", bus.ftoi_out_rst);
                    end else begin
                        e = sb.pop_front();
                        chk("out_res", bus.ftoi_out_rst, e.res);
                        chk("out_flags", {27'd0, bus.ftoi_out_fflags}, {27'd0, e.fl});
                        chk("out_tag", 32'(bus.ftoi_out_tag), 32'(e.tag));
                    end
                end
                hold  = bus.ftoi_out_vld && !bus.ftoi_out_rdy;
                h_res = bus.ftoi_out_rst;
                h_fl  = bus.ftoi_out_fflags;
                h_tag = bus.ftoi_out_tag;
            end
        end
    end

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        rdy_mode         = 0;
        tag_cnt          = '0;
        rst              = 1'b1;
        bus.ftoi_flush   = 1'b0;
        bus.ftoi_in_vld  = 1'b0;
        bus.ftoi_in_src  = 32'd0;
        bus.ftoi_in_sign = 1'b0;
        bus.ftoi_in_rm   = 3'd0;
        bus.ftoi_in_tag  = '0;
        bus.ftoi_out_rdy = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_out_vld", {31'd0, bus.ftoi_out_vld}, 32'd0);
        chk("rst_out_res", bus.ftoi_out_rst, 32'd0);
        chk("rst_out_flags", {27'd0, bus.ftoi_out_fflags}, 32'd0);
        chk("rst_out_tag", 32'(bus.ftoi_out_tag), 32'd0);
        chk("rst_in_rdy", {31'd0, bus.ftoi_in_rdy}, 32'd1);
        @(posedge clk);
        #1;

        // Directed values with hand-derived expectations
        send(32'h40490FDB, 1'b1, 3'd0, 32'h0000_0003, 5'b00001);
        send(32'h3FC00000, 1'b1, 3'd0, 32'h0000_0002, 5'b00001);
        send(32'h3F000000, 1'b1, 3'd0, 32'h0000_0000, 5'b00001);
        send(32'h3F000000, 1'b1, 3'd4, 32'h0000_0001, 5'b00001);
        send(32'hCF000000, 1'b1, 3'd0, 32'h8000_0000, 5'b00000);
        send(32'h4F000000, 1'b1, 3'd0, 32'h7FFF_FFFF, 5'b10000);
        send(32'h4F000000, 1'b0, 3'd0, 32'h8000_0000, 5'b00000);
        send(32'h7FC00000, 1'b1, 3'd0, 32'h7FFF_FFFF, 5'b10000);
        send(32'h7FC00000, 1'b0, 3'd0, 32'hFFFF_FFFF, 5'b10000);
        send(32'hFF800000, 1'b0, 3'd0, 32'h0000_0000, 5'b10000);
        send(32'hFF800000, 1'b1, 3'd0, 32'h8000_0000, 5'b10000);
        send(32'h7F800000, 1'b0, 3'd1, 32'hFFFF_FFFF, 5'b10000);
        send(32'hBE99999A, 1'b0, 3'd1, 32'h0000_0000, 5'b00001);
        send(32'hBE99999A, 1'b0, 3'd2, 32'h0000_0000, 5'b10000);
        send(32'hBE99999A, 1'b1, 3'd2, 32'hFFFF_FFFF, 5'b00001);
        send(32'h00000001, 1'b1, 3'd3, 32'h0000_0001, 5'b00001);
        send(32'h80000000, 1'b0, 3'd0, 32'h0000_0000, 5'b00000);
        send(32'h4F800000, 1'b0, 3'd0, 32'hFFFF_FFFF, 5'b10000);
        send(32'hCF000001, 1'b1, 3'd0, 32'h8000_0000, 5'b10000);
        send(32'h4F7FFFFF, 1'b0, 3'd1, 32'hFFFF_FF00, 5'b00000);
        send(32'h3FA00000, 1'b1, 3'd7, 32'h0000_0001, 5'b00001);
        drain();

        // Back-pressure: out_rdy held low while four ops are offered
        @(negedge clk);
        rdy_mode = 2;
        @(posedge clk);
        #1;
        fork
            begin
                send_m(32'h41200000, 1'b1, 3'd0);
                send_m(32'hC1A80000, 1'b1, 3'd0);
                send_m(32'h42F70000, 1'b0, 3'd1);
                send_m(32'h3F400000, 1'b1, 3'd4);
            end
            begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                chk("bp_in_rdy_low", {31'd0, bus.ftoi_in_rdy}, 32'd0);
                chk("bp_out_vld", {31'd0, bus.ftoi_out_vld}, 32'd1);
                repeat (2) @(negedge clk);
                rdy_mode = 0;
            end
        join
        drain();

        // Flush with both stages full and a new operation offered
        @(negedge clk);
        rdy_mode = 2;
        @(posedge clk);
        #1;
        send_m(32'h40490FDB, 1'b1, 3'd0);
        send_m(32'h3FC00000, 1'b1, 3'd0);
        bus.ftoi_in_vld = 1'b1;
        bus.ftoi_in_src = 32'h41000000;
        bus.ftoi_flush  = 1'b1;
        @(negedge clk);
        chk("flush_in_rdy", {31'd0, bus.ftoi_in_rdy}, 32'd0);
        chk("flush_full_before", {31'd0, bus.ftoi_out_vld}, 32'd1);
        @(posedge clk);
        #1;
        bus.ftoi_flush  = 1'b0;
        bus.ftoi_in_vld = 1'b0;
        chk("flush_out_vld", {31'd0, bus.ftoi_out_vld}, 32'd0);
        sb.delete();
        @(negedge clk);
        rdy_mode = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("flush_nothing_emitted", {31'd0, bus.ftoi_out_vld}, 32'd0);

        // Random operations against the reference model with random out_rdy
        rdy_mode = 1;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] s;
            logic [7:0]  ex;
            logic        sg;
            logic [2:0]  rm;
            case ($urandom_range(0, 9))
                0:       ex = 8'd0;
                1:       ex = 8'hFF;
                2:       ex = 8'($urandom_range(155, 160));
                default: ex = 8'($urandom_range(120, 165));
            endcase
            s[31]    = 1'($urandom_range(0, 1));
            s[30:23] = ex;
            s[22:0]  = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
            sg       = 1'($urandom_range(0, 1));
            rm       = 3'($urandom_range(0, 7));
            send_m(s, sg, rm);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();

        // Asynchronous reset with operations in flight
        tag_cnt = 5'd7;
        @(negedge clk);
        rdy_mode = 2;
        @(posedge clk);
        #1;
        send_m(32'h40490FDB, 1'b1, 3'd0);
        send_m(32'hC1A80000, 1'b1, 3'd0);
        #1;
        chk("pre_rst_out_vld", {31'd0, bus.ftoi_out_vld}, 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_out_vld", {31'd0, bus.ftoi_out_vld}, 32'd0);
        chk("arst_out_res", bus.ftoi_out_rst, 32'd0);
        chk("arst_out_flags", {27'd0, bus.ftoi_out_fflags}, 32'd0);
        chk("arst_out_tag", 32'(bus.ftoi_out_tag), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_idle", {31'd0, bus.ftoi_out_vld}, 32'd0);
        send(32'h3F000000, 1'b1, 3'd4, 32'h0000_0001, 5'b00001);
        send(32'hC0200000, 1'b1, 3'd0, 32'hFFFF_FFFE, 5'b00001);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
